riscv_lsu_ctrl: RTL and testbench
=================================

RISCV_LSU_CTRL -- requirements
Module: riscv_lsu_ctrl

Interface
REQ-001 SHALL have parameter: TIMEOUT, default 16, max BUSY cycles awaiting mem_ready_i before abort (range 1..255).
REQ-002 SHALL have clk_i  in  1  single clock; all state updates on rising edge.
REQ-003 SHALL have rst_ni  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have core_req_i  in  1  memory instruction in current stage (decoder mem_req).
REQ-005 SHALL have core_we_i  in  1  1 = store, 0 = load.
REQ-006 SHALL have core_size_i  in  3  B=0, H=1, W=2, BU=4, HU=5; other codes illegal.
REQ-007 SHALL have core_addr_i  in  32  byte address from ALU.
REQ-008 SHALL have core_wd_i  in  32  store data (rs2).
REQ-009 SHALL have core_rd_o  out  32  formatted load result, registered.
REQ-010 SHALL have core_stall_o  out  1  hold core (PC, pipeline) this cycle.
REQ-011 SHALL have fault_o  out  1  one-cycle pulse: misaligned, illegal size or timeout.
REQ-012 SHALL have mem_req_o / mem_we_o  out  1 / 1  data-memory request / write.
REQ-013 SHALL have mem_be_o  out  4  byte enables; mem_addr_o  out  32  byte address; mem_wd_o  out  32  write data.
REQ-014 SHALL have mem_rd_i  in  32  read word; mem_ready_i  in  1  access complete this cycle.

Function
REQ-015 SHALL implement FSM IDLE, BUSY, DONE.
REQ-016 IDLE, core_req_i=1, legal and aligned: SHALL capture we/size/addr/formatted wd/be into registers, set core_stall_o=1 (combinational), go BUSY.
REQ-017 Alignment: H/HU require addr[0]=0; W requires addr[1:0]=0; B/BU always aligned.
REQ-018 IDLE with misaligned or illegal size: SHALL assert fault_o for that cycle, core_stall_o=0, no memory access, stay IDLE.
REQ-019 BUSY: SHALL drive mem_req_o=1 and mem_we_o/mem_be_o/mem_addr_o/mem_wd_o from captured registers only, core_stall_o=1.
REQ-020 BUSY with mem_ready_i=1: SHALL go DONE; on load, register formatted mem_rd_i into core_rd_o.
REQ-021 BUSY: SHALL count wait cycles from 0; mem_ready_i=0 with count=TIMEOUT-1 SHALL assert fault_o that cycle, drop mem_req_o next cycle, go DONE, core_rd_o unchanged.
REQ-022 mem_ready_i and timeout in the same cycle: ready wins, no fault.
REQ-023 DONE: core_stall_o=0, mem_req_o=0; unconditionally go IDLE next cycle (no request accepted in DONE).
REQ-024 Zero-wait access SHALL take 3 cycles (IDLE, BUSY, DONE); N wait states add N cycles.
REQ-025 core_req_i deasserting or inputs changing during BUSY SHALL NOT affect the transaction.
REQ-026 Byte enables: B/BU 4'b0001<<addr[1:0]; H/HU 4'b0011 (addr[1]=0) or 4'b1100; W 4'b1111.
REQ-027 Store data: B replicates wd[7:0] x4; H replicates wd[15:0] x2; W passes wd.
REQ-028 Load: select byte/half by addr[1:0]/addr[1]; B/H sign-extend; BU/HU zero-extend; W full word.
REQ-029 mem_addr_o SHALL carry the full captured byte address.
REQ-030 In IDLE/DONE mem_we_o and mem_be_o SHALL be 0.

Reset
REQ-031 rst_ni=0 at any time, including mid-BUSY, SHALL immediately force IDLE, wait counter 0, all captured registers 0, core_rd_o=0, mem_req_o=0, mem_we_o=0, mem_be_o=0, fault_o=0.
REQ-032 core_stall_o during reset SHALL follow REQ-016/REQ-018 with state IDLE; first transaction accepted on first edge after rst_ni rises.

Verification
REQ-033 LW addr 0x100, mem_ready_i=1 first BUSY cycle, mem_rd_i=0xDEADBEEF -> stall 1,1,0; core_rd_o=0xDEADBEEF in DONE; mem_be_o=1111.
REQ-034 LB addr 0x103, mem_rd_i=0x80FF_0000 -> be=1000, core_rd_o=0xFFFFFF80; LBU same -> 0x00000080.
REQ-035 SH addr 0x202, wd=0x1234ABCD -> mem_we_o=1, be=1100, mem_wd_o=0xABCDABCD; SH addr 0x201 -> fault_o pulse, mem_req_o stays 0.
REQ-036 LW, mem_ready_i held 0, TIMEOUT=4 -> 4 BUSY cycles, fault_o on 4th, DONE, core_rd_o unchanged.
REQ-037 rst_ni low during BUSY with 2 wait states -> mem_req_o=0 and state IDLE asynchronously; next LW after release completes normally.
REQ-038 Back-to-back SW then LW, zero wait -> 6 cycles total, one DONE between, no double issue.

Source files
------------

// File: rtl/riscv_lsu_ctrl.sv
// Load/store unit controller: accepts one memory instruction at a time from
// the core, stalls the pipeline while the data-memory access is in flight,
// formats store data / byte enables on the way out and load data on the way
// back, and flags misaligned, illegal-size and timed-out accesses.
module riscv_lsu_ctrl #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        core_req_i,
  input  logic        core_we_i,
  input  logic [2:0]  core_size_i,
  input  logic [31:0] core_addr_i,
  input  logic [31:0] core_wd_i,
  output logic [31:0] core_rd_o,
  output logic        core_stall_o,
  output logic        fault_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wd_o,
  input  logic [31:0] mem_rd_i,
  input  logic        mem_ready_i
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  localparam logic [2:0] SZ_B  = 3'd0;
  localparam logic [2:0] SZ_H  = 3'd1;
  localparam logic [2:0] SZ_W  = 3'd2;
  localparam logic [2:0] SZ_BU = 3'd4;
  localparam logic [2:0] SZ_HU = 3'd5;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [2:0]  size_q, size_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wd_q, wd_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] rd_q, rd_d;
  logic        req_ok;
  logic        fault;

  function automatic logic size_legal(input logic [2:0] size);
    case (size)
      SZ_B, SZ_H, SZ_W, SZ_BU, SZ_HU: return 1'b1;
      default:                        return 1'b0;
    endcase
  endfunction

  // Low two size bits encode access width (0 byte, 1 half, 2 word).
  function automatic logic addr_aligned(input logic [2:0] size, input logic [1:0] off);
    case (size[1:0])
      2'd1:    return ~off[0];
      2'd2:    return (off == 2'b00);
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] fmt_be(input logic [2:0] size, input logic [1:0] off);
    case (size[1:0])
      2'd0:    return 4'b0001 << off;
      2'd1:    return off[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  // Replicate narrow store data across the word so every lane carries it.
  function automatic logic [31:0] fmt_wd(input logic [2:0] size, input logic [31:0] wd);
    case (size[1:0])
      2'd0:    return {4{wd[7:0]}};
      2'd1:    return {2{wd[15:0]}};
      default: return wd;
    endcase
  endfunction

  // Extract the addressed lane and sign- or zero-extend it.
  function automatic logic [31:0] fmt_rd(input logic [2:0] size, input logic [1:0] off,
                                         input logic [31:0] rd);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    b = 8'(rd >> {off, 3'b000});
    h = 16'(rd >> {off[1], 4'b0000});
    case (size)
      SZ_B:    return 32'(b);
      SZ_BU:   return {24'd0, b};
      SZ_H:    return 32'(h);
      SZ_HU:   return {16'd0, h};
      default: return rd;
    endcase
  endfunction

  assign req_ok = size_legal(core_size_i) && addr_aligned(core_size_i, core_addr_i[1:0]);

  // Next-state, capture and output decode for the IDLE/BUSY/DONE controller.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    we_d         = we_q;
    size_d       = size_q;
    addr_d       = addr_q;
    wd_d         = wd_q;
    be_d         = be_q;
    rd_d         = rd_q;
    core_stall_o = 1'b0;
    fault        = 1'b0;
    mem_req_o    = 1'b0;
    mem_we_o     = 1'b0;
    mem_be_o     = 4'b0000;
    case (state_q)
      IDLE: begin
        if (core_req_i) begin
          if (req_ok) begin
            we_d         = core_we_i;
            size_d       = core_size_i;
            addr_d       = core_addr_i;
            wd_d         = fmt_wd(core_size_i, core_wd_i);
            be_d         = fmt_be(core_size_i, core_addr_i[1:0]);
            cnt_d        = 8'd0;
            core_stall_o = 1'b1;
            state_d      = BUSY;
          end else begin
            fault = 1'b1;
          end
        end
      end
      BUSY: begin
        mem_req_o    = 1'b1;
        mem_we_o     = we_q;
        mem_be_o     = be_q;
        core_stall_o = 1'b1;
        if (mem_ready_i) begin
          if (!we_q) rd_d = fmt_rd(size_q, addr_q[1:0], mem_rd_i);
          cnt_d   = 8'd0;
          state_d = DONE;
        end else if (cnt_q == CNT_LAST) begin
          fault   = 1'b1;
          cnt_d   = 8'd0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign mem_addr_o = addr_q;
  assign mem_wd_o   = wd_q;
  assign core_rd_o  = rd_q;
  // Fault is held low while reset is asserted, even if the core presents a bad request.
  assign fault_o    = fault & rst_ni;

  // State, wait counter, captured request and load result registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      we_q    <= 1'b0;
      size_q  <= 3'd0;
      addr_q  <= 32'd0;
      wd_q    <= 32'd0;
      be_q    <= 4'd0;
      rd_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      size_q  <= size_d;
      addr_q  <= addr_d;
      wd_q    <= wd_d;
      be_q    <= be_d;
      rd_q    <= rd_d;
    end
  end

endmodule

// File: tb/tb_riscv_lsu_ctrl.sv
// Self-checking bench for riscv_lsu_ctrl: directed scenarios plus randomized
// transactions compared cycle by cycle against a behavioural model.
module tb_riscv_lsu_ctrl;

  localparam int TMO = 4;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        core_req_i;
  logic        core_we_i;
  logic [2:0]  core_size_i;
  logic [31:0] core_addr_i;
  logic [31:0] core_wd_i;
  logic [31:0] core_rd_o;
  logic        core_stall_o;
  logic        fault_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wd_o;
  logic [31:0] mem_rd_i;
  logic        mem_ready_i;

  int          tests = 0;
  int          fails = 0;
  logic [31:0] exp_rd;

  riscv_lsu_ctrl #(.TIMEOUT(TMO)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .core_req_i   (core_req_i),
    .core_we_i    (core_we_i),
    .core_size_i  (core_size_i),
    .core_addr_i  (core_addr_i),
    .core_wd_i    (core_wd_i),
    .core_rd_o    (core_rd_o),
    .core_stall_o (core_stall_o),
    .fault_o      (fault_o),
    .mem_req_o    (mem_req_o),
    .mem_we_o     (mem_we_o),
    .mem_be_o     (mem_be_o),
    .mem_addr_o   (mem_addr_o),
    .mem_wd_o     (mem_wd_o),
    .mem_rd_i     (mem_rd_i),
    .mem_ready_i  (mem_ready_i)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic bit m_legal(input logic [2:0] s);
    return s inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
  endfunction

  function automatic int m_bytes(input logic [2:0] s);
    if (s == 3'd0 || s == 3'd4) return 1;
    if (s == 3'd1 || s == 3'd5) return 2;
    return 4;
  endfunction

  function automatic bit m_aligned(input logic [2:0] s, input logic [31:0] a);
    return (int'(a[1:0]) % m_bytes(s)) == 0;
  endfunction

  function automatic int m_off(input logic [2:0] s, input logic [31:0] a);
    int b;
    b = m_bytes(s);
    return (int'(a[1:0]) / b) * b;
  endfunction

  function automatic logic [31:0] m_be(input logic [2:0] s, input logic [31:0] a);
    return 32'(((1 << m_bytes(s)) - 1) << m_off(s, a));
  endfunction

  function automatic logic [31:0] m_wd(input logic [2:0] s, input logic [31:0] w);
    case (m_bytes(s))
      1:       return 32'(w[7:0]) * 32'h01010101;
      2:       return 32'(w[15:0]) * 32'h00010001;
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] s, input logic [31:0] a,
                                         input logic [31:0] m);
    longint v;
    int     b;
    b = m_bytes(s);
    v = (longint'(m) >> (8 * m_off(s, a))) & ((longint'(1) << (8 * b)) - 1);
    if (b < 4 && !s[2] && v >= (longint'(1) << (8 * b - 1)))
      v = v - (longint'(1) << (8 * b));
    return 32'(v);
  endfunction

  // ---------------- checking helpers ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One complete transaction from the IDLE cycle through DONE.
  task automatic txn(input logic we, input logic [2:0] size, input logic [31:0] addr,
                     input logic [31:0] wd, input logic [31:0] mrd, input int wait_n);
    bit ok, rdy, tmo, fin;
    int c;
    @(negedge clk_i);
    core_req_i  = 1'b1;
    core_we_i   = we;
    core_size_i = size;
    core_addr_i = addr;
    core_wd_i   = wd;
    mem_ready_i = 1'b0;
    mem_rd_i    = $urandom;
    #1;
    ok = m_legal(size) && m_aligned(size, addr);
    chk("idle_mem_req", 32'(mem_req_o), 32'(1'b0));
    chk("idle_we", 32'(mem_we_o), 32'(1'b0));
    chk("idle_be", 32'(mem_be_o), 32'(4'd0));
    chk("idle_stall", 32'(core_stall_o), 32'(ok));
    chk("idle_fault", 32'(fault_o), 32'(!ok));
    if (!ok) begin
      @(negedge clk_i);
      core_req_i = 1'b0;
      #1;
      chk("post_fault_mem_req", 32'(mem_req_o), 32'(1'b0));
      chk("post_fault_fault", 32'(fault_o), 32'(1'b0));
      chk("post_fault_rd", core_rd_o, exp_rd);
      return;
    end
    c   = 0;
    fin = 1'b0;
    while (!fin) begin
      @(negedge clk_i);
      core_req_i  = 1'($urandom);
      core_we_i   = 1'($urandom);
      core_size_i = 3'($urandom);
      core_addr_i = $urandom;
      core_wd_i   = $urandom;
      rdy         = (c == wait_n);
      tmo         = !rdy && (c == TMO - 1);
      mem_ready_i = rdy;
      mem_rd_i    = rdy ? mrd : $urandom;
      #1;
      chk("busy_mem_req", 32'(mem_req_o), 32'(1'b1));
      chk("busy_we", 32'(mem_we_o), 32'(we));
      chk("busy_be", 32'(mem_be_o), m_be(size, addr));
      chk("busy_addr", mem_addr_o, addr);
      chk("busy_wd", mem_wd_o, we ? m_wd(size, wd) : mem_wd_o & 32'hFFFFFFFF);
      chk("busy_stall", 32'(core_stall_o), 32'(1'b1));
      chk("busy_fault", 32'(fault_o), 32'(tmo));
      if (rdy && !we) exp_rd = m_load(size, addr, mrd);
      fin = rdy || tmo;
      c++;
    end
    // DONE: present a legal request that must be ignored.
    @(negedge clk_i);
    core_req_i  = 1'b1;
    core_we_i   = 1'b0;
    core_size_i = 3'd2;
    core_addr_i = 32'h0;
    mem_ready_i = 1'b0;
    #1;
    chk("done_stall", 32'(core_stall_o), 32'(1'b0));
    chk("done_mem_req", 32'(mem_req_o), 32'(1'b0));
    chk("done_we", 32'(mem_we_o), 32'(1'b0));
    chk("done_be", 32'(mem_be_o), 32'(4'd0));
    chk("done_fault", 32'(fault_o), 32'(1'b0));
    chk("done_rd", core_rd_o, exp_rd);
  endtask

  task automatic idle_cycle();
    @(negedge clk_i);
    core_req_i  = 1'b0;
    mem_ready_i = 1'b0;
    #1;
    chk("idle_gap_mem_req", 32'(mem_req_o), 32'(1'b0));
    chk("idle_gap_stall", 32'(core_stall_o), 32'(1'b0));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_ni      = 1'b0;
    core_req_i  = 1'b0;
    core_we_i   = 1'b0;
    core_size_i = 3'd0;
    core_addr_i = 32'h0;
    core_wd_i   = 32'h0;
    mem_rd_i    = 32'h0;
    mem_ready_i = 1'b0;
    exp_rd      = 32'h0;
    repeat (2) @(negedge clk_i);
    #1;
    chk("rst_rd", core_rd_o, 32'h0);
    chk("rst_mem_req", 32'(mem_req_o), 32'(1'b0));
    chk("rst_be", 32'(mem_be_o), 32'(4'd0));
    chk("rst_addr", mem_addr_o, 32'h0);
    chk("rst_stall", 32'(core_stall_o), 32'(1'b0));
    chk("rst_fault", 32'(fault_o), 32'(1'b0));
    @(negedge clk_i);
    rst_ni = 1'b1;

    // LW zero-wait.
    txn(1'b0, 3'd2, 32'h100, 32'h0, 32'hDEADBEEF, 0);
    chk("lw_rd_const", core_rd_o, 32'hDEADBEEF);
    // LB / LBU at byte 3.
    txn(1'b0, 3'd0, 32'h103, 32'h0, 32'h80FF0000, 0);
    chk("lb_rd_const", core_rd_o, 32'hFFFFFF80);
    txn(1'b0, 3'd4, 32'h103, 32'h0, 32'h80FF0000, 0);
    chk("lbu_rd_const", core_rd_o, 32'h00000080);
    // SH upper half, then misaligned SH and an illegal size.
    txn(1'b1, 3'd1, 32'h202, 32'h1234ABCD, 32'h0, 1);
    chk("sh_keeps_rd", core_rd_o, 32'h00000080);
    txn(1'b1, 3'd1, 32'h201, 32'h1234ABCD, 32'h0, 0);
    txn(1'b0, 3'd3, 32'h200, 32'h0, 32'h0, 0);
    // LH / LHU on upper half.
    txn(1'b0, 3'd1, 32'h42, 32'h0, 32'h9ABC1234, 2);
    chk("lh_rd_const", core_rd_o, 32'hFFFF9ABC);
    txn(1'b0, 3'd5, 32'h42, 32'h0, 32'h9ABC1234, 0);
    chk("lhu_rd_const", core_rd_o, 32'h00009ABC);
    // Timeout: load result must not change.
    txn(1'b0, 3'd2, 32'h300, 32'h0, 32'h55555555, 99);
    chk("tmo_rd_const", core_rd_o, 32'h00009ABC);
    // Ready on the last allowed cycle wins over timeout.
    txn(1'b0, 3'd2, 32'h304, 32'h0, 32'h0BADF00D, TMO - 1);
    // Back-to-back SW then LW.
    txn(1'b1, 3'd2, 32'h400, 32'hCAFEBABE, 32'h0, 0);
    txn(1'b0, 3'd2, 32'h400, 32'h0, 32'h13579BDF, 0);
    idle_cycle();

    // Asynchronous reset in the middle of a BUSY access.
    @(negedge clk_i);
    core_req_i  = 1'b1;
    core_we_i   = 1'b0;
    core_size_i = 3'd2;
    core_addr_i = 32'h500;
    @(negedge clk_i);
    core_req_i = 1'b0;
    #1;
    chk("pre_rst_mem_req", 32'(mem_req_o), 32'(1'b1));
    #2;
    rst_ni = 1'b0;
    #1;
    exp_rd = 32'h0;
    chk("arst_mem_req", 32'(mem_req_o), 32'(1'b0));
    chk("arst_stall", 32'(core_stall_o), 32'(1'b0));
    chk("arst_be", 32'(mem_be_o), 32'(4'd0));
    chk("arst_rd", core_rd_o, 32'h0);
    chk("arst_addr", mem_addr_o, 32'h0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    txn(1'b0, 3'd2, 32'h600, 32'h0, 32'h2468ACE0, 0);
    chk("post_rst_lw_const", core_rd_o, 32'h2468ACE0);

    // Randomized transactions, including illegal sizes, misalignment and timeouts.
    for (int i = 0; i < 60; i++) begin
      txn(1'($urandom), 3'($urandom), $urandom, $urandom, $urandom,
          int'($urandom_range(0, TMO + 1)));
    end
    idle_cycle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

●
